// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the memory subsystem.
package mem_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int BANK_DEPTH = 32;

    // Base of the RAM window; the top address bit selects RAM.
    localparam logic [ADDR_W-1:0] RAM_BASE = 6'h20;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_DONE
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port-write, asynchronous-read storage bank. Contents are never reset.
module mem_array #(
    parameter int BANK_DEPTH = 32,
    parameter int DATA_W     = 8,
    parameter int IDX_W      = $clog2(BANK_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [BANK_DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_subsys.sv
// CPU-facing memory subsystem: one ROM bank (preloadable) and one RAM bank behind
// a shared tri-state data bus, sequenced by a small access FSM.
module mem_subsys
    import mem_pkg::*;
#(
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int BANK_DEPTH = mem_pkg::BANK_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd,
    input  logic                          wr,
    input  logic [ADDR_W-1:0]             addr,
    inout  wire  [DATA_W-1:0]             data,
    output logic                          ram_sel,
    output logic                          rom_sel,
    output logic                          ready,
    output logic                          wr_err,
    input  logic                          load_en,
    input  logic [$clog2(BANK_DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]             load_data
);

    localparam int IDX_W = $clog2(BANK_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              wr_err_q, wr_err_d;
    logic              latch_addr;
    logic              ram_we, rom_we;
    logic              drive;
    logic [DATA_W-1:0] rom_rdata, ram_rdata;

    assign ram_sel = addr[ADDR_W-1] & (rd | wr);
    assign rom_sel = ~addr[ADDR_W-1] & (rd | wr);

    // Bank writes are suppressed while reset is held so an aborted access never commits.
    mem_array #(
        .BANK_DEPTH (BANK_DEPTH),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we & ~reset),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (addr_q[IDX_W-1:0]),
        .rdata (rom_rdata)
    );

    mem_array #(
        .BANK_DEPTH (BANK_DEPTH),
        .DATA_W     (DATA_W),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .waddr (addr[IDX_W-1:0]),
        .wdata (data),
        .raddr (addr_q[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    // Next-state, strobes and register updates for the access sequencer.
    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        wr_err_d   = wr_err_q;
        latch_addr = 1'b0;
        ram_we     = 1'b0;
        rom_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd && !wr) begin
                    latch_addr = 1'b1;
                    state_d    = RD_WAIT;
                end else if (wr && !rd) begin
                    ready_d = 1'b1;
                    state_d = WR_DONE;
                    if (addr[ADDR_W-1]) begin
                        ram_we = 1'b1;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end else if (rd && wr) begin
                    // Conflicting strobes: flag it and stay put.
                    wr_err_d = 1'b1;
                end else if (load_en) begin
                    rom_we = 1'b1;
                end
            end
            RD_WAIT: begin
                rdata_d = addr_q[ADDR_W-1] ? ram_rdata : rom_rdata;
                ready_d = 1'b1;
                state_d = RD_DRIVE;
            end
            RD_DRIVE: begin
                if (!rd) begin
                    state_d = IDLE;
                end
            end
            WR_DONE: begin
                if (!wr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; ROM/RAM contents are deliberately outside reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            wr_err_q <= wr_err_d;
            if (latch_addr) begin
                addr_q <= addr;
            end
        end
    end

    assign ready  = ready_q;
    assign wr_err = wr_err_q;

    assign drive = (state_q == RD_DRIVE) && rd && !wr;
    assign data  = drive ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_subsys.sv
// Directed self-checking bench for mem_subsys.
module tb_mem_subsys;
    import mem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd, wr;
    logic [5:0] addr;
    wire  [7:0] data;
    logic       ram_sel, rom_sel, ready, wr_err;
    logic       load_en;
    logic [4:0] load_addr;
    logic [7:0] load_data;

    // Bench-side bus driver; drives a known value when probing bus release.
    logic       tb_drive;
    logic [7:0] tb_data;
    assign data = tb_drive ? tb_data : 8'hzz;

    int vectors = 0;
    int fails   = 0;

    mem_subsys dut (
        .clk       (clk),
        .reset     (reset),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .data      (data),
        .ram_sel   (ram_sel),
        .rom_sel   (rom_sel),
        .ready     (ready),
        .wr_err    (wr_err),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [5:0] ram5;
        logic [5:0] rom3;
        logic [5:0] rom7;
        ram5 = RAM_BASE | 6'd5;
        rom3 = 6'h03;
        rom7 = 6'h07;

        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        tb_drive = 1'b0; tb_data = '0;
        #1;
        chk("reset_ready", {7'd0, ready}, 8'd0);
        chk("reset_wr_err", {7'd0, wr_err}, 8'd0);
        chk("idle_ram_sel", {7'd0, ram_sel}, 8'd0);
        chk("idle_rom_sel", {7'd0, rom_sel}, 8'd0);
        tick(); tick();
        reset = 1'b0;

        // ROM preload: ROM[3]=A5, ROM[7]=C3.
        load_en = 1'b1; load_addr = 5'd3; load_data = 8'hA5; tick();
        load_addr = 5'd7; load_data = 8'hC3; tick();
        load_en = 1'b0;

        // ROM read of 0x03.
        addr = rom3; rd = 1'b1; #1;
        chk("rom_rd_rom_sel", {7'd0, rom_sel}, 8'd1);
        chk("rom_rd_ram_sel", {7'd0, ram_sel}, 8'd0);
        tick();
        chk("rom_rd_wait_ready", {7'd0, ready}, 8'd0);
        tick();
        chk("rom_rd_data", data, 8'hA5);
        chk("rom_rd_ready_pulse", {7'd0, ready}, 8'd1);
        tick();
        chk("rom_rd_ready_drop", {7'd0, ready}, 8'd0);
        chk("rom_rd_data_hold", data, 8'hA5);
        rd = 1'b0; tb_drive = 1'b1; tb_data = 8'h00; #1;
        chk("rom_rd_release", data, 8'h00);
        tick();
        tb_drive = 1'b0;

        // RAM write 0x25 <= 3C.
        addr = ram5; wr = 1'b1; tb_drive = 1'b1; tb_data = 8'h3C; #1;
        chk("ram_wr_ram_sel", {7'd0, ram_sel}, 8'd1);
        tick();
        chk("ram_wr_ready", {7'd0, ready}, 8'd1);
        chk("ram_wr_no_err", {7'd0, wr_err}, 8'd0);
        tick();
        chk("ram_wr_ready_drop", {7'd0, ready}, 8'd0);
        wr = 1'b0; tb_drive = 1'b0; tick();

        // RAM read back.
        rd = 1'b1; tick(); tick();
        chk("ram_rd_data", data, 8'h3C);
        chk("ram_rd_ready", {7'd0, ready}, 8'd1);
        rd = 1'b0; tick();

        // Write attempt into ROM.
        addr = rom3; wr = 1'b1; tb_drive = 1'b1; tb_data = 8'hFF; tick();
        chk("rom_wr_err", {7'd0, wr_err}, 8'd1);
        chk("rom_wr_ready", {7'd0, ready}, 8'd1);
        wr = 1'b0; tb_drive = 1'b0; tick();
        chk("rom_wr_err_sticky", {7'd0, wr_err}, 8'd1);
        rd = 1'b1; tick(); tick();
        chk("rom_wr_unchanged", data, 8'hA5);
        rd = 1'b0; tick();

        // Conflicting rd and wr in IDLE.
        addr = ram5; rd = 1'b1; wr = 1'b1; tb_drive = 1'b1; tb_data = 8'h77; tick();
        chk("rdwr_no_ready", {7'd0, ready}, 8'd0);
        chk("rdwr_err", {7'd0, wr_err}, 8'd1);
        chk("rdwr_bus_undriven", data, 8'h77);
        tick();
        chk("rdwr_no_ready_2", {7'd0, ready}, 8'd0);
        rd = 1'b0; wr = 1'b0; tb_drive = 1'b0; tick();
        rd = 1'b1; tick(); tick();
        chk("rdwr_ram_unchanged", data, 8'h3C);
        rd = 1'b0; tick();

        // load_en during RAM read, plus addr change during RD_WAIT.
        addr = ram5; rd = 1'b1; load_en = 1'b1; load_addr = 5'd3; load_data = 8'h11; tick();
        addr = rom7; tick();
        chk("latched_addr_data", data, 8'h3C);
        rd = 1'b0; load_en = 1'b0; tick();
        addr = rom3; rd = 1'b1; tick(); tick();
        chk("load_en_ignored", data, 8'hA5);
        rd = 1'b0; tick();

        // Reset asserted in the first RD_DRIVE cycle.
        addr = ram5; rd = 1'b1; tick(); tick();
        chk("pre_reset_data", data, 8'h3C);
        chk("pre_reset_ready", {7'd0, ready}, 8'd1);
        reset = 1'b1; tb_drive = 1'b1; tb_data = 8'h00; #1;
        chk("reset_mid_ready", {7'd0, ready}, 8'd0);
        chk("reset_mid_wr_err", {7'd0, wr_err}, 8'd0);
        chk("reset_mid_release", data, 8'h00);
        #2;
        reset = 1'b0; rd = 1'b0; tb_drive = 1'b0;
        tick();
        rd = 1'b1; tick(); tick();
        chk("ram_kept_after_reset", data, 8'h3C);
        chk("wr_err_clear_after_reset", {7'd0, wr_err}, 8'd0);
        rd = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
